// File: rtl/cp_rddt_conv_pkg.sv
// Constants shared by the host-side read and write data converters of the CP output buffer.
// Holds the state encodings, the word-select one-hots and the address widths.
package cp_rddt_conv_pkg;

    localparam int LINE_AW = 7;
    localparam int WORD_AW = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [3:0] WSEL_0 = 4'b0001;
    localparam logic [3:0] WSEL_1 = 4'b0010;
    localparam logic [3:0] WSEL_2 = 4'b0100;
    localparam logic [3:0] WSEL_3 = 4'b1000;

    function automatic logic [3:0] wordSelOf(input logic [WORD_AW-1:0] wordAddr);
        logic [3:0] sel;
        case (wordAddr)
            2'd0:    sel = WSEL_0;
            2'd1:    sel = WSEL_1;
            2'd2:    sel = WSEL_2;
            default: sel = WSEL_3;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/cp_rddt_conv_word_mux.sv
// 128-to-32 word select driven by a one-hot word select.
// An invalid one-hot yields zero rather than a blend of words.
module cp_rd_word_mux
    import cp_rddt_conv_pkg::*;
(
    input  logic [127:0] line,
    input  logic [3:0]   wordSel,
    output logic [31:0]  word
);

    always_comb begin
        word = 32'h0;
        case (wordSel)
            WSEL_0:  word = line[31:0];
            WSEL_1:  word = line[63:32];
            WSEL_2:  word = line[95:64];
            WSEL_3:  word = line[127:96];
            default: word = 32'h0;
        endcase
    end

endmodule

// File: rtl/cp_rddt_conv.sv
// Serves 32-bit host reads from the 128-bit AES output buffer through a one-line cache.
// Hits answer in one cycle; misses fetch the line with a RD_LAT-cycle buffer read.
module cp_rddt_conv
    import cp_rddt_conv_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic               iRdEn_OutBuf,
    input  logic [8:0]         iRdAddr_OutBuf,
    input  logic               iLineInv,
    output logic               oRdRdy_OutBuf,
    output logic               oRdDtVld_OutBuf,
    output logic [31:0]        oRdDt_OutBuf,
    output logic               oRdEn_CpOutBuf,
    output logic [LINE_AW-1:0] oRdAddr_CpOutBuf,
    input  logic [127:0]       iRdDt_CpOutBuf
);

    logic [1:0]         state;
    logic               lineVld;
    logic [LINE_AW-1:0] lineTag;
    logic [127:0]       lineDt;
    logic [LINE_AW-1:0] reqLine;
    logic [3:0]         wordSel;
    logic [2:0]         latCnt;
    logic               invSeen;
    logic               hitVld;
    logic               hit;
    logic [31:0]        selWord;

    assign hit = lineVld & (iRdAddr_OutBuf[8:2] == lineTag) & ~iLineInv;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state   <= ST_IDLE;
            lineVld <= 1'b0;
            lineTag <= '0;
            lineDt  <= '0;
            reqLine <= '0;
            wordSel <= '0;
            latCnt  <= '0;
            invSeen <= 1'b0;
            hitVld  <= 1'b0;
        end else begin
            hitVld <= 1'b0;
            case (state)
                ST_IDLE, ST_RESP: begin
                    state <= ST_IDLE;
                    if (iLineInv) lineVld <= 1'b0;
                    if (iRdEn_OutBuf) begin
                        wordSel <= wordSelOf(iRdAddr_OutBuf[1:0]);
                        if (hit) begin
                            hitVld <= 1'b1;
                        end else begin
                            reqLine <= iRdAddr_OutBuf[8:2];
                            invSeen <= 1'b0;
                            state   <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    latCnt <= 3'(RD_LAT);
                    if (iLineInv) invSeen <= 1'b1;
                    state <= ST_WAIT;
                end
                default: begin
                    // An invalidate anywhere in the fetch window keeps the new line from being cached.
                    if (latCnt == 3'd1) begin
                        lineDt  <= iRdDt_CpOutBuf;
                        lineTag <= reqLine;
                        lineVld <= ~(invSeen | iLineInv);
                        state   <= ST_RESP;
                    end else begin
                        latCnt <= 3'(latCnt - 3'd1);
                        if (iLineInv) invSeen <= 1'b1;
                    end
                end
            endcase
        end
    end

    cp_rd_word_mux uWordMux (
        .line    (lineDt),
        .wordSel (wordSel),
        .word    (selWord)
    );

    assign oRdRdy_OutBuf    = (state == ST_IDLE) | (state == ST_RESP);
    assign oRdDtVld_OutBuf  = hitVld | (state == ST_RESP);
    assign oRdDt_OutBuf     = oRdDtVld_OutBuf ? selWord : 32'h0;
    assign oRdEn_CpOutBuf   = (state == ST_FETCH);
    assign oRdAddr_CpOutBuf = oRdEn_CpOutBuf ? reqLine : '0;

endmodule

// File: tb/tb_cp_rddt_conv.sv
// Bench for cp_rddt_conv: RD_LAT=1 instance checked through a response scoreboard,
// RD_LAT=3 instance checked cycle by cycle for latency.
module tb_cp_rddt_conv;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, rdEn, lineInv;
    logic [8:0]   rdAddr;
    logic         rdy, vld, bufEn;
    logic [31:0]  rdDt;
    logic [6:0]   bufAddr;
    logic [127:0] bufDt;

    logic         rdEn3, lineInv3;
    logic [8:0]   rdAddr3;
    logic         rdy3, vld3, bufEn3;
    logic [31:0]  rdDt3;
    logic [6:0]   bufAddr3;
    logic [127:0] bufDt3;

    logic [127:0] mem [128];
    logic [31:0]  expQ [$];
    int nTests = 0;
    int nFail = 0;
    int fetchCnt = 0;
    int f0;
    bit monEn = 1'b0;

    cp_rddt_conv #(.RD_LAT(1)) dut (
        .iClk(clk), .iRst(rst), .iRdEn_OutBuf(rdEn), .iRdAddr_OutBuf(rdAddr),
        .iLineInv(lineInv), .oRdRdy_OutBuf(rdy), .oRdDtVld_OutBuf(vld),
        .oRdDt_OutBuf(rdDt), .oRdEn_CpOutBuf(bufEn), .oRdAddr_CpOutBuf(bufAddr),
        .iRdDt_CpOutBuf(bufDt)
    );

    cp_rddt_conv #(.RD_LAT(3)) dut3 (
        .iClk(clk), .iRst(rst), .iRdEn_OutBuf(rdEn3), .iRdAddr_OutBuf(rdAddr3),
        .iLineInv(lineInv3), .oRdRdy_OutBuf(rdy3), .oRdDtVld_OutBuf(vld3),
        .oRdDt_OutBuf(rdDt3), .oRdEn_CpOutBuf(bufEn3), .oRdAddr_CpOutBuf(bufAddr3),
        .iRdDt_CpOutBuf(bufDt3)
    );

    // Buffer models: data valid RD_LAT cycles after the strobe, garbage otherwise.
    logic       pv1 = 1'b0;
    logic [6:0] pa1 = '0;
    logic [2:0] pv3 = '0;
    logic [6:0] pa3 [3] = '{default: '0};
    always @(posedge clk) begin
        pv1    <= bufEn;
        pa1    <= bufAddr;
        pv3    <= {pv3[1:0], bufEn3};
        pa3[0] <= bufAddr3;
        pa3[1] <= pa3[0];
        pa3[2] <= pa3[1];
    end
    assign bufDt  = pv1    ? mem[pa1]    : {4{32'hDEADBEEF}};
    assign bufDt3 = pv3[2] ? mem[pa3[2]] : {4{32'hDEADBEEF}};

    task automatic chkVal(input string tag, input logic [127:0] act, input logic [127:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] wordOf(input logic [8:0] a);
        logic [127:0] ln;
        ln = mem[a[8:2]];
        return ln[int'(a[1:0])*32 +: 32];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [8:0] a);
        rdEn = 1'b1;
        rdAddr = a;
        expQ.push_back(wordOf(a));
        tick();
        rdEn = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 30; i++) begin
            if (expQ.size() == 0) break;
            tick();
        end
        chkVal("drain", 128'(expQ.size()), 128'(0));
        tick();
    endtask

    always @(negedge clk) begin
        if (monEn) begin
            if (bufEn) fetchCnt++;
            if (vld) begin
                if (expQ.size() == 0) chkVal("unexpVld", 128'(1), 128'(0));
                else chkVal("rdDt", 128'(rdDt), 128'(expQ.pop_front()));
            end else begin
                chkVal("dtIdleZero", 128'(rdDt), 128'(0));
            end
        end
    end

    initial begin
        for (int i = 0; i < 128; i++)
            for (int w = 0; w < 4; w++)
                mem[i][w*32 +: 32] = {8'(i), 8'(w), 16'hC0DE};
        mem[5] = 128'h44444444_33333333_22222222_11111111;

        rst = 1'b1; rdEn = 1'b0; rdAddr = '0; lineInv = 1'b0;
        rdEn3 = 1'b0; rdAddr3 = '0; lineInv3 = 1'b0;
        tick(); tick();
        @(negedge clk);
        chkVal("rstRdy", 128'(rdy), 128'(1));
        chkVal("rstVld", 128'(vld), 128'(0));
        chkVal("rstDt", 128'(rdDt), 128'(0));
        chkVal("rstBufEn", 128'(bufEn), 128'(0));
        chkVal("rstBufAddr", 128'(bufAddr), 128'(0));
        chkVal("rstRdy3", 128'(rdy3), 128'(1));
        rst = 1'b0;
        monEn = 1'b1;
        tick();

        // Miss on line 5, then three hits back-to-back starting in the response cycle
        f0 = fetchCnt;
        rdEn = 1'b1; rdAddr = 9'h014; expQ.push_back(32'h11111111);
        tick();
        rdEn = 1'b0;
        @(negedge clk);
        chkVal("missStrobe", 128'(bufEn), 128'(1));
        chkVal("missAddr", 128'(bufAddr), 128'(5));
        chkVal("missRdyLow", 128'(rdy), 128'(0));
        tick();
        @(negedge clk);
        chkVal("waitVld", 128'(vld), 128'(0));
        chkVal("waitAddr0", 128'(bufAddr), 128'(0));
        tick();
        @(negedge clk);
        chkVal("respVld", 128'(vld), 128'(1));
        chkVal("respRdy", 128'(rdy), 128'(1));
        rdEn = 1'b1; rdAddr = 9'h015; expQ.push_back(32'h22222222);
        tick();
        rdAddr = 9'h016; expQ.push_back(32'h33333333);
        @(negedge clk);
        chkVal("hitVld1", 128'(vld), 128'(1));
        tick();
        rdAddr = 9'h017; expQ.push_back(32'h44444444);
        @(negedge clk);
        chkVal("hitVld2", 128'(vld), 128'(1));
        tick();
        rdEn = 1'b0;
        @(negedge clk);
        chkVal("hitVld3", 128'(vld), 128'(1));
        tick();
        @(negedge clk);
        chkVal("hitEnd", 128'(vld), 128'(0));
        tick();
        chkVal("hitFetches", 128'(fetchCnt - f0), 128'(1));

        // Miss on line 6 with the request held through FETCH/WAIT
        f0 = fetchCnt;
        rdEn = 1'b1; rdAddr = 9'h018; expQ.push_back(wordOf(9'h018));
        tick(); tick(); tick();
        rdEn = 1'b0;
        @(negedge clk);
        chkVal("heldRespVld", 128'(vld), 128'(1));
        drain(); tick(); tick();
        chkVal("heldFetches", 128'(fetchCnt - f0), 128'(1));

        // Invalidate alongside a would-be hit
        f0 = fetchCnt;
        rdEn = 1'b1; rdAddr = 9'h019; lineInv = 1'b1; expQ.push_back(wordOf(9'h019));
        tick();
        rdEn = 1'b0; lineInv = 1'b0;
        @(negedge clk);
        chkVal("invMissStrobe", 128'(bufEn), 128'(1));
        chkVal("invMissAddr", 128'(bufAddr), 128'(6));
        drain();
        chkVal("invFetches", 128'(fetchCnt - f0), 128'(1));
        f0 = fetchCnt;
        req(9'h01A); drain();
        chkVal("hitAfterRefetch", 128'(fetchCnt - f0), 128'(0));

        // Invalidate during WAIT: word delivered, line not kept
        f0 = fetchCnt;
        rdEn = 1'b1; rdAddr = 9'h01C; expQ.push_back(wordOf(9'h01C));
        tick();
        rdEn = 1'b0;
        tick();
        lineInv = 1'b1;
        tick();
        lineInv = 1'b0;
        drain();
        req(9'h01D); drain();
        chkVal("invWaitFetches", 128'(fetchCnt - f0), 128'(2));

        // Reset in WAIT: no response, held line dropped
        rdEn = 1'b1; rdAddr = 9'h020;
        tick();
        rdEn = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chkVal("rstMidRdy", 128'(rdy), 128'(1));
        chkVal("rstMidVld", 128'(vld), 128'(0));
        chkVal("rstMidBufEn", 128'(bufEn), 128'(0));
        tick(); tick(); tick(); tick();
        f0 = fetchCnt;
        req(9'h01D); drain();
        chkVal("missAfterRst", 128'(fetchCnt - f0), 128'(1));

        // Top line, last and first words
        f0 = fetchCnt;
        req(9'h1FF); drain();
        req(9'h1FC); drain();
        chkVal("topLineFetches", 128'(fetchCnt - f0), 128'(1));

        // RD_LAT=3 latency
        rdEn3 = 1'b1; rdAddr3 = 9'h024;
        tick();
        rdEn3 = 1'b0;
        @(negedge clk);
        chkVal("lat3Strobe", 128'(bufEn3), 128'(1));
        chkVal("lat3Addr", 128'(bufAddr3), 128'(9));
        chkVal("lat3RdyT1", 128'(rdy3), 128'(0));
        for (int k = 2; k <= 4; k++) begin
            tick();
            @(negedge clk);
            chkVal("lat3RdyLow", 128'(rdy3), 128'(0));
            chkVal("lat3VldLow", 128'(vld3), 128'(0));
        end
        tick();
        @(negedge clk);
        chkVal("lat3Vld", 128'(vld3), 128'(1));
        chkVal("lat3Dt", 128'(rdDt3), 128'(wordOf(9'h024)));
        chkVal("lat3Rdy", 128'(rdy3), 128'(1));
        tick();
        @(negedge clk);
        chkVal("lat3VldEnd", 128'(vld3), 128'(0));

        chkVal("queueEmpty", 128'(expQ.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/cp_rddt_conv.md
Name: cp_rddt_conv

Overview:
- Read-side counterpart of the host-to-core write data conversion: serves 32-bit host reads from the 128-bit AES output buffer (7-bit line address).
- Holds one 128-bit line in a local line register. Reads that hit the held line take 1 cycle; misses fetch the line from the buffer.
- Sits between the host read interface and the core output buffer.
- Word ordering is identical to the write path: addr[1:0]=0 selects bits [31:0] and addr[1:0]=3 selects bits [127:96].

Parameters:
- RD_LAT, 1: buffer read latency in cycles from oRdEn_CpOutBuf high to iRdDt_CpOutBuf valid; legal range 1..4.

Ports:
- iClk  input  1  clock; all logic on rising edge.
- iRst  input  1  synchronous reset, active-high.
- iRdEn_OutBuf  input  1  host read request; sampled only while oRdRdy_OutBuf=1.
- iRdAddr_OutBuf  input  9  host word address; [8:2]=line, [1:0]=word.
- iLineInv  input  1  core has rewritten the output buffer; invalidates the held line.
- oRdRdy_OutBuf  output  1  block can accept a request this cycle.
- oRdDtVld_OutBuf  output  1  one-cycle pulse; oRdDt_OutBuf is valid.
- oRdDt_OutBuf  output  32  read word; 32'h0 whenever oRdDtVld_OutBuf=0.
- oRdEn_CpOutBuf  output  1  buffer read strobe, one cycle per fetch.
- oRdAddr_CpOutBuf  output  7  buffer line address; 7'h0 when oRdEn_CpOutBuf=0.
- iRdDt_CpOutBuf  input  128  buffer read data, valid RD_LAT cycles after the strobe.

Behaviour:
- Reset: state IDLE, line-valid=0, line tag=0, line data=0. Outputs after reset: oRdRdy_OutBuf=1, all other outputs 0.
- State register: IDLE, FETCH, WAIT, RESP.
- Held line:
  - hit = line-valid & (iRdAddr_OutBuf[8:2]==tag) & ~iLineInv.
  - iLineInv has priority over a same-cycle hit; that request is handled as a miss.
- IDLE, oRdRdy_OutBuf=1:
  - iRdEn_OutBuf & hit: next cycle oRdDtVld_OutBuf=1 with the selected word; stay in IDLE. Back-to-back hits sustain 1 word/cycle.
  - iRdEn_OutBuf & miss: latch line address and word select; go to FETCH.
  - No request: stay in IDLE.
- FETCH (1 cycle): oRdEn_CpOutBuf=1, oRdAddr_CpOutBuf=latched line; load latency counter with RD_LAT; go to WAIT.
- WAIT: decrement counter each cycle. When it expires, capture iRdDt_CpOutBuf into line data and set tag=latched line; go to RESP.
  - With RD_LAT=1 the capture happens in the cycle after FETCH.
- RESP (1 cycle): oRdDtVld_OutBuf=1, selected word from the captured line; oRdRdy_OutBuf=1; IDLE rules apply to a request in this cycle; go to IDLE.
- Miss latency: request accepted in cycle T; oRdEn_CpOutBuf high in T+1; oRdDtVld_OutBuf high in T+2+RD_LAT. For RD_LAT=1 that is T+3.
- oRdRdy_OutBuf=0 in FETCH and WAIT. An iRdEn_OutBuf in those cycles is ignored: no response and no state change.
- line-valid rules:
  - Set on capture, unless iLineInv was seen at any point since FETCH. In that case the fetched word is still delivered, but line-valid stays 0.
  - iLineInv in IDLE or RESP clears line-valid on the next edge.
- Reset mid-fetch: returns to IDLE immediately, no oRdDtVld_OutBuf pulse; late buffer data is ignored.
- Word select: one-hot from addr[1:0] (0001/0010/0100/1000); the mux output is zero if the one-hot is invalid.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'd0, FETCH=2'd1, WAIT=2'd2, RESP=2'd3;
  - word-select one-hot constants, shared with the write converter;
  - line/word address width constants: 7 and 2.
- One natural sub-module: cp_rd_word_mux, a combinational 128-to-32 select by one-hot word select.

Test Plan:
1. Reset, then buffer line 5 = 128'h44444444_33333333_22222222_11111111; read addr 9'h014 -> oRdEn_CpOutBuf at T+1 with addr 7'h05; oRdDtVld_OutBuf at T+3 with 32'h11111111.
2. Continue reads 9'h015, 9'h016, 9'h017 back-to-back -> no oRdEn_CpOutBuf; data 32'h22222222, 32'h33333333, 32'h44444444 on three consecutive cycles.
3. Read 9'h018 (line 6, miss) -> new fetch with addr 7'h06; hold iRdEn_OutBuf high during FETCH/WAIT -> extra requests ignored, exactly one response.
4. iLineInv pulsed together with a read of 9'h019 (would hit) -> handled as a miss and re-fetched. iLineInv during WAIT -> word delivered; the next read of the same line re-fetches.
5. RD_LAT=3: miss at T -> strobe at T+1, oRdDtVld_OutBuf at T+5; oRdRdy_OutBuf low in T+1..T+4.
6. iRst asserted in WAIT -> next cycle all outputs 0 and oRdRdy_OutBuf=1; no oRdDtVld_OutBuf pulse; the next read of the previous line misses.
